register_file: RTL and testbench

//  MIPS general-purpose register file: 32 x 32-bit, two combinational read ports, one synchronous write port.

---
 rtl/register_file_pkg.sv | 13 +
 rtl/register_file_read_port.sv | 30 +++
 rtl/register_file.sv | 77 +++++++
 tb/tb_register_file.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared MIPS definitions: architectural register indices and default register-file geometry.
package mips_defs;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam logic [31:0] DEF_SP_RESET = 32'h0000_3FFC;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: $zero forcing, optional same-cycle write bypass, else stored value.
module regfile_read_port
  import mips_defs::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BYPASS     = 1
) (
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] data
);

  // index != 0 already implies writeReg != 0 on a bypass match.
  always_comb begin
    data = '0;
    if (index != ADDR_WIDTH'(REG_ZERO)) begin
      if ((BYPASS != 0) && !reset && regWrite && (writeReg == index)) begin
        data = writeData;
      end else begin
        data = regs[index];
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// MIPS GPR file: 32 x 32-bit, two combinational read ports, one synchronous write port, $0 hard-wired.
module register_file
  import mips_defs::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    BYPASS     = 1,
  parameter int                    SP_INDEX   = REG_SP,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = DATA_WIDTH'(DEF_SP_RESET)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  // Entry 0 has no storage; the read ports see a constant zero in its slot.
  logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] view [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (regWrite) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (writeReg == ADDR_WIDTH'(i)) begin
          regs[i] <= writeData;
        end
      end
    end
  end

  always_comb begin
    view[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      view[i] = regs[i];
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_rd1 (
    .reset     (reset),
    .index     (readReg1),
    .regs      (view),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .data      (readData1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_rd2 (
    .reset     (reset),
    .index     (readReg2),
    .regs      (view),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .data      (readData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: one bypassing and one non-bypassing instance share every input.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  always #50 clock = ~clock;

  register_file #(.BYPASS(1)) u_byp (
    .clock(clock), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .readData1(rd1_b), .readData2(rd2_b)
  );

  register_file #(.BYPASS(0)) u_nobyp (
    .clock(clock), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .readData1(rd1_n), .readData2(rd2_n)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [31:0] mdl [32];
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mdl[29] = 32'h0000_3FFC;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'h0;
    if (byp && !reset && regWrite && (writeReg == idx)) return writeData;
    return mdl[idx];
  endfunction

  // Push four expectations, let the combinational reads settle, then pop and compare.
  task automatic probe(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] e1b, input logic [31:0] e2b,
                       input logic [31:0] e1n, input logic [31:0] e2n);
    logic [31:0] obs [4];
    sb_entry_t   e;
    readReg1 = r1;
    readReg2 = r2;
    sb_q.push_back('{{tag, "_b1"}, e1b});
    sb_q.push_back('{{tag, "_b2"}, e2b});
    sb_q.push_back('{{tag, "_n1"}, e1n});
    sb_q.push_back('{{tag, "_n2"}, e2n});
    #1;
    obs[0] = rd1_b; obs[1] = rd2_b; obs[2] = rd1_n; obs[3] = rd2_n;
    for (int k = 0; k < 4; k++) begin
      e = sb_q.pop_front();
      check_val(e.tag, obs[k], e.exp);
    end
  endtask

  task automatic probe_model(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    probe(tag, r1, r2, model_read(r1, 1'b1), model_read(r2, 1'b1),
          model_read(r1, 1'b0), model_read(r2, 1'b0));
  endtask

  // One rising edge with the model following the storage update, then back to the falling edge.
  task automatic step();
    @(posedge clock);
    if (regWrite && !reset && writeReg != 5'd0) mdl[writeReg] = writeData;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0;

    // Reset pulse between edges, all registers read with no edge in between.
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 32; i++) begin
      probe($sformatf("rst_r%0d", i), 5'(i), 5'(31 - i),
            (i == 29) ? 32'h3FFC : 32'h0, (i == 2) ? 32'h3FFC : 32'h0,
            (i == 29) ? 32'h3FFC : 32'h0, (i == 2) ? 32'h3FFC : 32'h0);
    end
    reset = 1'b0;
    probe("rst_rel", 5'd29, 5'd1, 32'h3FFC, 32'h0, 32'h3FFC, 32'h0);
    @(negedge clock);

    // Basic write/read.
    regWrite = 1'b1; writeReg = 5'd8; writeData = 32'd100; step();
    writeReg = 5'd9; writeData = 32'd200; step();
    regWrite = 1'b0;
    probe("rw_89", 5'd8, 5'd9, 32'd100, 32'd200, 32'd100, 32'd200);
    probe("rw_98", 5'd9, 5'd8, 32'd200, 32'd100, 32'd200, 32'd100);

    // $zero is never written.
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFF_FFFF;
    probe("zero_pre", 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    regWrite = 1'b0;
    probe("zero_post", 5'd0, 5'd8, 32'h0, 32'd100, 32'h0, 32'd100);

    // Enable gating over three edges.
    writeReg = 5'd8; writeData = 32'd999;
    for (int i = 0; i < 3; i++) step();
    probe("gate", 5'd8, 5'd8, 32'd100, 32'd100, 32'd100, 32'd100);

    // Same-cycle bypass versus old value.
    regWrite = 1'b1; writeReg = 5'd10; writeData = 32'd5; step();
    writeData = 32'd77;
    probe("byp_pre", 5'd10, 5'd10, 32'd77, 32'd77, 32'd5, 32'd5);
    step();
    regWrite = 1'b0;
    probe("byp_post", 5'd10, 5'd10, 32'd77, 32'd77, 32'd77, 32'd77);

    // Reset asserted mid-operation while a write is presented.
    regWrite = 1'b1; writeReg = 5'd12; writeData = 32'd123; step();
    regWrite = 1'b0;
    probe("r12_set", 5'd12, 5'd12, 32'd123, 32'd123, 32'd123, 32'd123);
    regWrite = 1'b1; writeData = 32'd456;
    #10;
    reset = 1'b1;
    model_reset();
    probe("rmid_now", 5'd12, 5'd10, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    probe("rmid_edge", 5'd12, 5'd29, 32'h0, 32'h3FFC, 32'h0, 32'h3FFC);
    reset = 1'b0; regWrite = 1'b0;
    probe("rmid_rel", 5'd12, 5'd8, 32'h0, 32'h0, 32'h0, 32'h0);

    // Randomised traffic checked against the bench model.
    for (int n = 0; n < 300; n++) begin
      regWrite  = 1'($urandom_range(0, 1));
      writeReg  = 5'($urandom_range(0, 31));
      writeData = $urandom;
      if (n % 4 == 0) probe_model($sformatf("rnd%0d", n), writeReg, writeReg);
      else probe_model($sformatf("rnd%0d", n), 5'($urandom_range(0, 31)), writeReg);
      step();
    end
    regWrite = 1'b0;
    for (int i = 0; i < 32; i++) probe_model($sformatf("final_r%0d", i), 5'(i), 5'(31 - i));

    if (sb_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL sb_drain: got %0d leftover expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
